// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, counter-based debounce, and one-cycle press/release/long-press events.
// The release event port is named release_evt because `release` is a reserved word in SystemVerilog.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES   = 120000,
  parameter int LONG_PRESS_CYCLES = 12000000,
  parameter bit ACTIVE_LOW        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn,
  output logic press,
  output logic release_evt,
  output logic long_press
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HMAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HLAST = HW'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } state_t;

  state_t        state;
  logic          sync1, s;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;

  // Inversion happens ahead of the first flop so the synchronizer resets to "released".
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= btn_raw ^ ACTIVE_LOW;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RELEASED;
      btn         <= 1'b0;
      dcnt        <= '0;
      hcnt        <= '0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_press  <= 1'b0;
      unique case (state)
        RELEASED, PRESS_WAIT: begin
          if (!s) begin
            state <= RELEASED;
            dcnt  <= '0;
          end else if (dcnt == DLAST) begin
            state <= PRESSED;
            dcnt  <= '0;
            btn   <= 1'b1;
            press <= 1'b1;
            hcnt  <= '0;
          end else begin
            state <= PRESS_WAIT;
            dcnt  <= dcnt + DW'(1);
          end
        end
        PRESSED, RELEASE_WAIT: begin
          if (!s && dcnt == DLAST) begin
            // Release wins over a long press due in the same cycle.
            state       <= RELEASED;
            dcnt        <= '0;
            btn         <= 1'b0;
            release_evt <= 1'b1;
            hcnt        <= '0;
          end else begin
            if (s) begin
              state <= PRESSED;
              dcnt  <= '0;
            end else begin
              state <= RELEASE_WAIT;
              dcnt  <= dcnt + DW'(1);
            end
            if (hcnt != HMAX) begin
              hcnt       <= hcnt + HW'(1);
              long_press <= (hcnt == HLAST);
            end
          end
        end
        default: begin
          state <= RELEASED;
          dcnt  <= '0;
          btn   <= 1'b0;
          hcnt  <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: window-based reference model checked every cycle on two instances
// (active-high and active-low pins), plus directed literal timing checks.
module tb_btn_debounce;
  localparam int DC  = 4;
  localparam int LPC = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw0 = 1'b1, raw1 = 1'b1;
  logic btn0, press0, rel0, lp0;
  logic btn1, press1, rel1, lp1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  btn_debounce #(.DEBOUNCE_CYCLES(DC), .LONG_PRESS_CYCLES(LPC), .ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .rst(rst), .btn_raw(raw0),
    .btn(btn0), .press(press0), .release_evt(rel0), .long_press(lp0));
  btn_debounce #(.DEBOUNCE_CYCLES(DC), .LONG_PRESS_CYCLES(LPC), .ACTIVE_LOW(1'b1)) u1 (
    .clk(clk), .rst(rst), .btn_raw(raw1),
    .btn(btn1), .press(press1), .release_evt(rel1), .long_press(lp1));

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  // Reference model: btn flips when the last DC synchronized samples all disagreed with it;
  // long_press fires exactly LPC cycles after the rising edge if btn is still high.
  logic ms1 [2], ms [2], mb [2], mp [2], mr [2], mlp [2];
  bit   qd  [2][$];
  int   pk  [2];
  int   k = 0;

  always begin
    logic pin [2];
    logic flip;
    @(posedge clk);
    pin[0] = raw0;
    pin[1] = ~raw1;
    k++;
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        ms1[u] = 0; ms[u] = 0; mb[u] = 0;
        mp[u] = 0; mr[u] = 0; mlp[u] = 0;
        qd[u].delete();
        pk[u] = -100000;
      end else begin
        qd[u].push_back(ms[u] != mb[u]);
        if (qd[u].size() > DC) void'(qd[u].pop_front());
        flip = (qd[u].size() == DC);
        for (int j = 0; j < qd[u].size(); j++)
          if (!qd[u][j]) flip = 0;
        ms[u]  = ms1[u];
        ms1[u] = pin[u];
        mp[u] = 0; mr[u] = 0;
        if (flip) begin
          mb[u] = ~mb[u];
          qd[u].delete();
          if (mb[u]) begin mp[u] = 1; pk[u] = k; end
          else mr[u] = 1;
        end
        mlp[u] = mb[u] && (k - pk[u] == LPC);
      end
    end
    #1;
    chk("btn0", btn0, mb[0]);   chk("press0", press0, mp[0]);
    chk("rel0", rel0, mr[0]);   chk("lp0", lp0, mlp[0]);
    chk("btn1", btn1, mb[1]);   chk("press1", press1, mp[1]);
    chk("rel1", rel1, mr[1]);   chk("lp1", lp1, mlp[1]);
  end

  initial begin
    int p_at, lp_at, lp_cnt, rel_at;

    // 1: reset held 3 cycles with the pin pressed
    repeat (3) begin
      @(negedge clk);
      chk("rst_btn", btn0, 1'b0);    chk("rst_press", press0, 1'b0);
      chk("rst_rel", rel0, 1'b0);    chk("rst_lp", lp0, 1'b0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk("post_rst_press", press0, (i == 6));
      chk("post_rst_rel", rel0, 1'b0);
    end

    // 2: clean release/press/release
    raw0 = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_btn", btn0, 1'b0);
    raw0 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("clean_press", press0, (i == 6));
      chk("clean_btn", btn0, (i >= 6));
      chk("clean_lp", lp0, 1'b0);
    end
    raw0 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("clean_rel", rel0, (i == 6));
      chk("clean_btn_low", btn0, (i < 6));
    end

    // 3: bounce every 3 cycles is rejected
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) raw0 = ~raw0;
      @(negedge clk);
      chk("bounce_btn", btn0, 1'b0);
      chk("bounce_press", press0, 1'b0);
    end
    raw0 = 1'b0;
    repeat (10) @(negedge clk);

    // 4: long press fires once, P+LPC
    raw0 = 1'b1;
    p_at = -1; lp_at = -1; lp_cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (press0) p_at = i;
      if (lp0) begin lp_at = i; lp_cnt++; end
    end
    n_cmp++;
    if (p_at != 6) begin n_err++; $display("FAIL long_press_p: got %0d want 6", p_at); end
    n_cmp++;
    if (lp_at != 26) begin n_err++; $display("FAIL long_press_at: got %0d want 26", lp_at); end
    n_cmp++;
    if (lp_cnt != 1) begin n_err++; $display("FAIL long_press_cnt: got %0d want 1", lp_cnt); end
    raw0 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("long_rel", rel0, (i == 6));
    end

    // 5: btn falls exactly at P+LPC; release wins
    raw0 = 1'b1;
    rel_at = -1; lp_cnt = 0;
    for (int i = 1; i <= 32; i++) begin
      if (i == 21) raw0 = 1'b0;
      @(negedge clk);
      if (rel0) rel_at = i;
      if (lp0) lp_cnt++;
    end
    n_cmp++;
    if (rel_at != 26) begin n_err++; $display("FAIL race_rel_at: got %0d want 26", rel_at); end
    n_cmp++;
    if (lp_cnt != 0) begin n_err++; $display("FAIL race_lp_cnt: got %0d want 0", lp_cnt); end

    // 6: active-low pin idles high
    chk("al_idle_btn", btn1, 1'b0);
    raw1 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("al_press", press1, (i == 6));
      chk("al_btn", btn1, (i >= 6));
    end
    raw1 = 1'b1;
    repeat (10) @(negedge clk);
    chk("al_btn_rel", btn1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
